// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - stage payload structs, widths, halt bit indices and buffer state encoding
package pipe_stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halt;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        halt;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        halt;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        halt;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // halt is the last packed field of every stage struct, so it lands on bit 0
    localparam int IF_ID_HALT_BIT  = 0;
    localparam int ID_EX_HALT_BIT  = 0;
    localparam int EX_MEM_HALT_BIT = 0;
    localparam int MEM_WB_HALT_BIT = 0;

    // {main_v, skid_v}; 2'b01 is unreachable
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter with synchronous reset
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - 2-entry skid pipeline stage with flush and halt detection; PIPE_STAGE_BUF_PERF_EN adds counters
module pipe_stage_buf
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH    = 42,
    parameter logic [WIDTH-1:0] BUBBLE   = '0,
    parameter int               HALT_BIT = 0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             halt_seen
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             acc;
    logic             out_fire;
    stage_state_e     state;

    assign state     = stage_state_e'({main_v, skid_v});
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_v ? main_d : BUBBLE;
    assign acc       = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_d    <= BUBBLE;
            skid_d    <= BUBBLE;
            halt_seen <= 1'b0;
        end else begin
            // a halt beat delivered in a flush cycle still counts
            if (out_fire && main_d[HALT_BIT]) begin
                halt_seen <= 1'b1;
            end
            if (flush) begin
                main_v <= 1'b0;
                skid_v <= 1'b0;
                main_d <= BUBBLE;
                skid_d <= BUBBLE;
            end else begin
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            main_v <= 1'b1;
                            main_d <= in_data;
                        end
                    end
                    ONE: begin
                        if (acc && out_fire) begin
                            main_d <= in_data;
                        end else if (acc) begin
                            skid_v <= 1'b1;
                            skid_d <= in_data;
                        end else if (out_fire) begin
                            main_v <= 1'b0;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            skid_v <= 1'b0;
                            main_d <= skid_d;
                        end
                    end
                    default: begin
                        main_v <= 1'b0;
                        skid_v <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(!main_v && skid_v))
                else $error("pipe_stage_buf: skid entry valid while main entry empty");
        end
    end

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_stage_buf: CNT_W must be at least 1");
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .value (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & (main_v | skid_v)),
        .value (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf against a queue model
module tb_pipe_stage_buf;

    localparam int         W     = 8;
    localparam logic [7:0] BUB   = 8'hEE;
    localparam int         HB    = 7;
    localparam int         CW    = 4;
    localparam int         CMAX  = 15;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, halt_seen;
    logic [7:0] out_data;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    pipe_stage_buf #(.WIDTH(W), .BUBBLE(BUB), .HALT_BIT(HB), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .halt_seen (halt_seen)
`ifdef PIPE_STAGE_BUF_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    logic [7:0] mq[$];
    bit         m_halt;
    int         m_stall, m_flush;
    logic [7:0] dut_log[$];
    logic [7:0] exp_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_len"}, dut_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++)
            if (i < dut_log.size()) chk(nm, dut_log[i], exp_log[i]);
    endtask

    // Model: the stage is a FIFO of at most two beats
    always @(posedge clk) begin
        bit fire;
        bit acc;
        fire = (mq.size() > 0) && out_ready;
        acc  = in_valid && (mq.size() < 2);
        if (reset) begin
            mq.delete();
            m_halt  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
            if (flush && mq.size() > 0 && m_flush < CMAX) m_flush++;
            if (fire && mq[0][HB]) m_halt = 1'b1;
            if (flush) mq.delete();
            else begin
                if (fire) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("out_data", out_data, (mq.size() > 0) ? mq[0] : BUB);
            chk("in_ready", in_ready, mq.size() < 2);
            chk("halt_seen", halt_seen, m_halt);
`ifdef PIPE_STAGE_BUF_PERF_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
`endif
            if (out_valid && out_ready && !reset) dut_log.push_back(out_data);
        end
    end

    task automatic tick(input bit r, input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
        reset     = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        tick(1, 0, 0, 0, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 8'hEE);
        chk("rst_halt", halt_seen, 0);

        // streaming
        dut_log.delete();
        tick(0, 1, 8'h01, 1, 0);
        chk("stream_latency", out_data, 8'h01);
        tick(0, 1, 8'h02, 1, 0);
        tick(0, 1, 8'h03, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        exp_log = '{8'h01, 8'h02, 8'h03};
        chk_log("stream_log");

        // backpressure
        dut_log.delete();
        tick(0, 1, 8'h0A, 0, 0);
        tick(0, 1, 8'h0B, 0, 0);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_data", out_data, 8'h0A);
        tick(0, 1, 8'h0C, 0, 0);
        tick(0, 1, 8'h0C, 1, 0);
        tick(0, 1, 8'h0C, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        exp_log = '{8'h0A, 8'h0B, 8'h0C};
        chk_log("bp_log");

        // flush in FULL with a new beat offered
        dut_log.delete();
        tick(0, 1, 8'h11, 0, 0);
        tick(0, 1, 8'h12, 0, 0);
        tick(0, 1, 8'h13, 0, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_data", out_data, 8'hEE);
        chk("flush_in_ready", in_ready, 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        chk("flush_log_len", dut_log.size(), 0);

        // halt flushed before delivery
        tick(0, 1, 8'h81, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("halt_flushed", halt_seen, 0);

        // halt stalled then delivered
        tick(0, 1, 8'h85, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("halt_stalled", halt_seen, 0);
        tick(0, 0, 0, 1, 0);
        chk("halt_fired", halt_seen, 1);
        tick(0, 1, 8'h21, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("halt_sticky", halt_seen, 1);

        // reset in FULL while flushing
        tick(0, 1, 8'h31, 0, 0);
        tick(0, 1, 8'h32, 0, 0);
        tick(1, 1, 8'h33, 0, 1);
        chk("rstfl_out_valid", out_valid, 0);
        chk("rstfl_in_ready", in_ready, 1);
        chk("rstfl_out_data", out_data, 8'hEE);
        chk("rstfl_halt", halt_seen, 0);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            tick(($urandom_range(0, 499) == 0), $urandom_range(0, 1), 8'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
        end

`ifdef PIPE_STAGE_BUF_PERF_EN
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 8'h05, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0);
        chk("stall_sat", stall_cnt, 15);
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 8'h01, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 8'h02, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("flush_cnt_lit", flush_cnt, 2);
`endif

        tick(0, 0, 0, 1, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
